// File: rtl/regs_wr_arb_if.sv
// Bundle for the regs_wr_arb write-port arbiter and read-hazard unit.
//   slave  : arbiter side (takes requests and read data, drives readys,
//            register file write port, delivered read data and hazards)
//   master : requesters / core / register file side
interface regs_wr_arb_if #(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic                  req0_valid;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;
  logic                  hold;
  logic                  w;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH-1:0] raddr1;
  logic [ADDR_WIDTH-1:0] raddr2;
  logic [DATA_WIDTH-1:0] data1_q;
  logic [DATA_WIDTH-1:0] data2_q;
  logic [DATA_WIDTH-1:0] rdata1;
  logic [DATA_WIDTH-1:0] rdata2;
  logic                  haz1;
  logic                  haz2;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  hold, raddr1, raddr2, data1_q, data2_q,
    output req0_ready, req1_ready, w, waddr, wdata,
    output rdata1, rdata2, haz1, haz2
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output hold, raddr1, raddr2, data1_q, data2_q,
    input  req0_ready, req1_ready, w, waddr, wdata,
    input  rdata1, rdata2, haz1, haz2
  );
endinterface

// File: rtl/regs_wr_arb.sv
// regs_wr_arb: round-robin arbiter for the picoMIPS register file write
// port, plus read-hazard detection / optional forwarding.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset
//   bus    : regs_wr_arb_if.slave (requests, readys, hold, w/waddr/wdata,
//            read addresses, register file read data, rdata/haz outputs)
// Build option: define REGS_ARB_FWD_EN to forward wdata around the
// register file on a read of the register being written; haz1/haz2 are
// then tied low. Default build reports hazards instead.
module regs_wr_arb #(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  regs_wr_arb_if.slave  bus
);

  logic                  last;
  logic                  w_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  grant0;
  logic                  grant1;
  logic                  hit1;
  logic                  hit2;

  // Round-robin grant: a lone requester wins; on a contest the one that
  // did not win last time wins. last=1 favours requester 0.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!bus.hold && !reset) begin
      grant0 = bus.req0_valid & (~bus.req1_valid | last);
      grant1 = bus.req1_valid & (~bus.req0_valid | ~last);
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // Output stage: never stalls, w pulses for exactly the cycle after a grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_q     <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      last    <= 1'b1;
    end else if (grant0) begin
      w_q     <= 1'b1;
      waddr_q <= bus.req0_addr;
      wdata_q <= bus.req0_data;
      last    <= 1'b0;
    end else if (grant1) begin
      w_q     <= 1'b1;
      waddr_q <= bus.req1_addr;
      wdata_q <= bus.req1_data;
      last    <= 1'b1;
    end else begin
      w_q     <= 1'b0;
    end
  end

  assign bus.w     = w_q;
  assign bus.waddr = waddr_q;
  assign bus.wdata = wdata_q;

  // The register file still returns the old value while its write is pending.
  assign hit1 = w_q & (bus.raddr1 == waddr_q);
  assign hit2 = w_q & (bus.raddr2 == waddr_q);

`ifdef REGS_ARB_FWD_EN
  assign bus.rdata1 = hit1 ? wdata_q : bus.data1_q;
  assign bus.rdata2 = hit2 ? wdata_q : bus.data2_q;
  assign bus.haz1   = 1'b0;
  assign bus.haz2   = 1'b0;
`else
  assign bus.rdata1 = bus.data1_q;
  assign bus.rdata2 = bus.data2_q;
  assign bus.haz1   = hit1;
  assign bus.haz2   = hit2;
`endif

endmodule

// File: tb/tb_regs_wr_arb.sv
// Directed bench for regs_wr_arb with a small register file model.
module tb_regs_wr_arb;
  localparam int unsigned AW = 2;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  regs_wr_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  regs_wr_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Register file model: cleared by reset, written on the edge after w rises.
  logic [DW-1:0] regs [4];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (bus.w) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end
  assign bus.data1_q = regs[bus.raddr1];
  assign bus.data2_q = regs[bus.raddr2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 2'd2;
    bus.req0_data  = 8'hA5;
    bus.req1_valid = 1'b0;
    bus.req1_addr  = '0;
    bus.req1_data  = '0;
    bus.hold       = 1'b0;
    bus.raddr1     = '0;
    bus.raddr2     = '0;

    // Reset with a pending request
    repeat (2) @(posedge clk);
    #2;
    check("rst_ready0", 32'(bus.req0_ready), 32'd0);
    check("rst_w", 32'(bus.w), 32'd0);
    check("rst_waddr", 32'(bus.waddr), 32'd0);
    check("rst_wdata", 32'(bus.wdata), 32'd0);
    check("rst_haz1", 32'(bus.haz1), 32'd0);

    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rel_ready0", 32'(bus.req0_ready), 32'd1);
    check("rel_ready1", 32'(bus.req1_ready), 32'd0);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    check("first_w", 32'(bus.w), 32'd1);
    check("first_waddr", 32'(bus.waddr), 32'd2);
    check("first_wdata", 32'(bus.wdata), 32'hA5);
    check("first_ready0", 32'(bus.req0_ready), 32'd0);
    tick();
    bus.raddr1 = 2'd2;
    #1;
    check("first_w_off", 32'(bus.w), 32'd0);
    check("first_reg2", 32'(bus.rdata1), 32'hA5);

    // Hold in the cycle after a transfer, req1 waiting
    tick();
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 2'd0;
    bus.req0_data  = 8'h77;
    #1;
    check("hold_pre_ready0", 32'(bus.req0_ready), 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 2'd1;
    bus.req1_data  = 8'h99;
    bus.hold       = 1'b1;
    #1;
    check("hold_w", 32'(bus.w), 32'd1);
    check("hold_wdata", 32'(bus.wdata), 32'h77);
    check("hold_ready1_a", 32'(bus.req1_ready), 32'd0);
    tick();
    #1;
    check("hold_w_off", 32'(bus.w), 32'd0);
    check("hold_ready1_b", 32'(bus.req1_ready), 32'd0);
    tick();
    bus.hold = 1'b0;
    #1;
    check("unhold_ready1", 32'(bus.req1_ready), 32'd1);
    tick();
    bus.req1_valid = 1'b0;
    #1;
    check("unhold_w", 32'(bus.w), 32'd1);
    check("unhold_waddr", 32'(bus.waddr), 32'd1);
    check("unhold_wdata", 32'(bus.wdata), 32'h99);

    // Round-robin with both requesters held valid
    tick();
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 2'd1;
    bus.req0_data  = 8'h11;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 2'd3;
    bus.req1_data  = 8'h33;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_ready0", 32'(bus.req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_ready1", 32'(bus.req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      check("rr_w", 32'(bus.w), (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) check("rr_waddr", 32'(bus.waddr), (i % 2 == 1) ? 32'd1 : 32'd3);
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    check("rr_last_w", 32'(bus.w), 32'd1);
    check("rr_last_waddr", 32'(bus.waddr), 32'd3);
    check("rr_last_wdata", 32'(bus.wdata), 32'h33);
    tick();
    #1;
    check("rr_done_w", 32'(bus.w), 32'd0);

    // Same-address race, last=1
    tick();
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 2'd0;
    bus.req0_data  = 8'h01;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 2'd0;
    bus.req1_data  = 8'h02;
    #1;
    check("race_ready0", 32'(bus.req0_ready), 32'd1);
    check("race_ready1", 32'(bus.req1_ready), 32'd0);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    check("race_ready1_b", 32'(bus.req1_ready), 32'd1);
    check("race_wdata_a", 32'(bus.wdata), 32'h01);
    tick();
    bus.req1_valid = 1'b0;
    #1;
    check("race_wdata_b", 32'(bus.wdata), 32'h02);
    tick();
    bus.raddr1 = 2'd0;
    #1;
    check("race_reg0", 32'(bus.rdata1), 32'h02);

    // Read hazard on port 1 during the w cycle for addr 2
    tick();
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 2'd2;
    bus.req0_data  = 8'h5C;
    #1;
    check("haz_ready0", 32'(bus.req0_ready), 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    bus.raddr1     = 2'd2;
    bus.raddr2     = 2'd3;
    #1;
    check("haz_w", 32'(bus.w), 32'd1);
`ifdef REGS_ARB_FWD_EN
    check("haz_rdata1", 32'(bus.rdata1), 32'h5C);
    check("haz_haz1", 32'(bus.haz1), 32'd0);
`else
    check("haz_rdata1", 32'(bus.rdata1), 32'hA5);
    check("haz_haz1", 32'(bus.haz1), 32'd1);
`endif
    check("haz_rdata2", 32'(bus.rdata2), 32'h33);
    check("haz_haz2", 32'(bus.haz2), 32'd0);
    tick();
    #1;
    check("haz_after_rdata1", 32'(bus.rdata1), 32'h5C);
    check("haz_after_haz1", 32'(bus.haz1), 32'd0);

    // Reset asserted while w is high
    tick();
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 2'd3;
    bus.req0_data  = 8'hEE;
    #1;
    check("mid_ready0", 32'(bus.req0_ready), 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    bus.raddr1     = 2'd3;
    #1;
    check("mid_w", 32'(bus.w), 32'd1);
    check("mid_waddr", 32'(bus.waddr), 32'd3);
    #1 reset = 1'b1;
    #1;
    check("mid_w_async", 32'(bus.w), 32'd0);
    check("mid_haz1", 32'(bus.haz1), 32'd0);
    @(posedge clk);
    #2;
    check("mid_reg3", 32'(bus.rdata1), 32'd0);
    check("mid_w_rst", 32'(bus.w), 32'd0);
    reset          = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 2'd1;
    bus.req0_data  = 8'h11;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 2'd2;
    bus.req1_data  = 8'h22;
    #1;
    check("post_ready0", 32'(bus.req0_ready), 32'd1);
    check("post_ready1", 32'(bus.req1_ready), 32'd0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    check("post_w", 32'(bus.w), 32'd1);
    check("post_wdata", 32'(bus.wdata), 32'h11);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
